// File: rtl/sync_fifo_flags_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags_pkg
//   Shared types and helpers for the sync_fifo_flags elastic buffer.
//   - fifo_mode_e : read-side behaviour (registered read or first-word-fall-through)
//   - ptr_next()  : pointer advance with explicit wrap, valid for any depth
// -----------------------------------------------------------------------------
package sync_fifo_flags_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Wraps depth-1 back to 0 explicitly so non-power-of-2 depths index the
  // storage array correctly instead of running past its end.
  function automatic int unsigned ptr_next(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_flags_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags_if
//   Bundles the FIFO control, data and status signals.
//   master : the user of the FIFO (drives requests, flush, clr_err, din)
//   slave  : the FIFO itself (drives dout, rd_valid, flags, level, errors)
//   Parameters must match the sync_fifo_flags instance it connects to.
// -----------------------------------------------------------------------------
interface sync_fifo_flags_if #(
  parameter int width = 8,
  parameter int depth = 16
);
  localparam int lw = $clog2(depth + 1);

  logic             flush;
  logic             wr_en;
  logic [width-1:0] din;
  logic             rd_en;
  logic             clr_err;
  logic [width-1:0] dout;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [lw-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, din, rd_en, clr_err,
    input  dout, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, din, rd_en, clr_err,
    output dout, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_flags_ptr_ctr.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags_ptr_ctr
//   Wrapping storage pointer, one instance each for write and read side.
//   clk     in  clock
//   rst     in  synchronous active-high reset, pointer -> 0
//   clear   in  synchronous clear (flush), pointer -> 0
//   advance in  step pointer by one, wrapping depth-1 -> 0
//   ptr     out current pointer value
// -----------------------------------------------------------------------------
module sync_fifo_flags_ptr_ctr
  import sync_fifo_flags_pkg::*;
#(
  parameter  int depth = 16,
  localparam int pw    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [pw-1:0] ptr
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= pw'(ptr_next(32'(ptr), depth));
    end
  end

endmodule

// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//   Single-clock parametrised FIFO with level/threshold flags, FWFT or
//   registered read, synchronous flush and sticky overflow/underflow errors.
//   Parameters: width, depth (>=2, any integer), af_level (1..depth),
//               ae_level (0..depth-1), fwft (1 = fall-through, 0 = registered)
//   Ports:
//     clk  in  clock, everything on posedge
//     rst  in  synchronous active-high reset, overrides all bus inputs
//     bus  slave modport of sync_fifo_flags_if:
//          flush/wr_en/din/rd_en/clr_err in; dout/rd_valid/full/empty/
//          almost_full/almost_empty/level/overflow/underflow out
// -----------------------------------------------------------------------------
module sync_fifo_flags
  import sync_fifo_flags_pkg::*;
#(
  parameter int width    = 8,
  parameter int depth    = 16,
  parameter int af_level = 12,
  parameter int ae_level = 2,
  parameter int fwft     = 1
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_flags_if.slave bus
);

  localparam int         pw   = $clog2(depth);
  localparam int         lw   = $clog2(depth + 1);
  localparam fifo_mode_e mode = (fwft != 0) ? FIFO_FWFT : FIFO_STD;

  if (depth < 2) begin : g_bad_depth
    $error("sync_fifo_flags: depth must be >= 2");
  end
  if (af_level < 1 || af_level > depth) begin : g_bad_af
    $error("sync_fifo_flags: af_level must be in 1..depth");
  end
  if (ae_level < 0 || ae_level > depth - 1) begin : g_bad_ae
    $error("sync_fifo_flags: ae_level must be in 0..depth-1");
  end

  logic [width-1:0] mem [depth];
  logic [pw-1:0]    wr_ptr;
  logic [pw-1:0]    rd_ptr;
  logic [lw-1:0]    level_q;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;
  logic             ovf_evt;
  logic             udf_evt;
  logic             overflow_q;
  logic             underflow_q;

  // Flags come straight from the level register, so they reflect the state
  // after the last edge and are what the accept logic sees before the next.
  assign full  = (level_q == lw'(depth));
  assign empty = (level_q == '0);

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    wr_acc  = 1'b0;
    rd_acc  = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    // Flush swallows same-cycle requests and raises no errors.
    if (!rst && !bus.flush) begin
      wr_acc  = bus.wr_en && !full;
      rd_acc  = bus.rd_en && !empty;
      ovf_evt = bus.wr_en && full;
      udf_evt = bus.rd_en && empty;
    end
  end

  sync_fifo_flags_ptr_ctr #(.depth(depth)) u_wr_ptr (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.flush),
    .advance (wr_acc),
    .ptr     (wr_ptr)
  );

  sync_fifo_flags_ptr_ctr #(.depth(depth)) u_rd_ptr (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.flush),
    .advance (rd_acc),
    .ptr     (rd_ptr)
  );

  // NOTE: storage is deliberately left out of reset; entries are only ever
  // read once the level says they have been written.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  // Simultaneous accepted write and pop cancel out.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      level_q <= '0;
    end else if (wr_acc && !rd_acc) begin
      level_q <= level_q + lw'(1);
    end else if (rd_acc && !wr_acc) begin
      level_q <= level_q - lw'(1);
    end
  end

  // A new error event in the same cycle as clr_err takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (ovf_evt)          overflow_q  <= 1'b1;
      else if (bus.clr_err) overflow_q  <= 1'b0;
      if (udf_evt)          underflow_q <= 1'b1;
      else if (bus.clr_err) underflow_q <= 1'b0;
    end
  end

  if (mode == FIFO_FWFT) begin : g_fwft
    // Head of queue is presented continuously; rd_en acknowledges it.
    assign bus.dout     = empty ? '0 : mem[rd_ptr];
    assign bus.rd_valid = !empty;
  end else begin : g_std
    logic [width-1:0] dout_q;
    logic             rd_valid_q;

    // dout holds its last value between reads; rd_valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= mem[rd_ptr];
        end
      end
    end

    assign bus.dout     = dout_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (level_q >= lw'(af_level));
  assign bus.almost_empty = (level_q <= lw'(ae_level));
  assign bus.level        = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
//   Three instances share clk/rst:
//     u_fwft : width 8, depth 16, af 12, ae 2, fall-through read
//     u_std  : same sizing, registered read (driven identically to u_fwft)
//     u_d5   : depth 5, fall-through, for pointer wrap on odd depth
//   u_fwft/u_std are compared every cycle against a queue-based model.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_flags_if #(.width(8), .depth(DEPTH)) b0 ();
  sync_fifo_flags_if #(.width(8), .depth(DEPTH)) bs ();
  sync_fifo_flags_if #(.width(8), .depth(5))     b5 ();

  sync_fifo_flags #(.width(8), .depth(DEPTH), .af_level(AF), .ae_level(AE), .fwft(1))
    u_fwft (.clk(clk), .rst(rst), .bus(b0));
  sync_fifo_flags #(.width(8), .depth(DEPTH), .af_level(AF), .ae_level(AE), .fwft(0))
    u_std (.clk(clk), .rst(rst), .bus(bs));
  sync_fifo_flags #(.width(8), .depth(5), .af_level(4), .ae_level(1), .fwft(1))
    u_d5 (.clk(clk), .rst(rst), .bus(b5));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: contents as a queue plus sticky errors and the
  // registered-read output of the fwft=0 instance.
  logic [7:0] mq[$];
  bit         m_ovf, m_udf, m_svalid;
  logic [7:0] m_sdout;

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         exp_level;
    bit         exp_full;
    bit         exp_af;
    bit         exp_ovf;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t tbl[33];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit f, input bit w, input logic [7:0] d,
                            input bit rd, input bit c);
    bit was_full, was_empty;
    if (r) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_sdout = '0; m_svalid = 0;
    end else if (f) begin
      mq.delete();
      m_sdout = '0; m_svalid = 0;
      if (c) begin m_ovf = 0; m_udf = 0; end
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (rd && !was_empty) begin
        m_sdout  = mq.pop_front();
        m_svalid = 1;
      end else begin
        m_svalid = 0;
      end
      if (w && !was_full) mq.push_back(d);
      if (w && was_full) m_ovf = 1; else if (c) m_ovf = 0;
      if (rd && was_empty) m_udf = 1; else if (c) m_udf = 0;
    end
  endtask

  task automatic check_model();
    int n;
    n = mq.size();
    check("level",        32'(b0.level),        32'(n));
    check("empty",        32'(b0.empty),        32'(n == 0));
    check("full",         32'(b0.full),         32'(n == DEPTH));
    check("almost_full",  32'(b0.almost_full),  32'(n >= AF));
    check("almost_empty", 32'(b0.almost_empty), 32'(n <= AE));
    check("overflow",     32'(b0.overflow),     32'(m_ovf));
    check("underflow",    32'(b0.underflow),    32'(m_udf));
    check("fwft_dout",    32'(b0.dout),         (n != 0) ? 32'(mq[0]) : 32'd0);
    check("fwft_valid",   32'(b0.rd_valid),     32'(n != 0));
    check("std_level",    32'(bs.level),        32'(n));
    check("std_dout",     32'(bs.dout),         32'(m_sdout));
    check("std_valid",    32'(bs.rd_valid),     32'(m_svalid));
    check("std_overflow", 32'(bs.overflow),     32'(m_ovf));
  endtask

  // One clock on u_fwft and u_std with identical inputs, then model compare.
  task automatic cycle(input bit r, input bit f, input bit w, input logic [7:0] d,
                       input bit rd, input bit c);
    rst = r;
    b0.flush = f; b0.wr_en = w; b0.din = d; b0.rd_en = rd; b0.clr_err = c;
    bs.flush = f; bs.wr_en = w; bs.din = d; bs.rd_en = rd; bs.clr_err = c;
    @(posedge clk);
    model_step(r, f, w, d, rd, c);
    #1;
    rst = 0;
    b0.flush = 0; b0.wr_en = 0; b0.rd_en = 0; b0.clr_err = 0;
    bs.flush = 0; bs.wr_en = 0; bs.rd_en = 0; bs.clr_err = 0;
    check_model();
  endtask

  task automatic cycle5(input bit w, input logic [7:0] d, input bit rd);
    b5.wr_en = w; b5.din = d; b5.rd_en = rd;
    @(posedge clk);
    #1;
    b5.wr_en = 0; b5.rd_en = 0;
  endtask

  initial begin
    b0.flush = 0; b0.wr_en = 0; b0.din = '0; b0.rd_en = 0; b0.clr_err = 0;
    bs.flush = 0; bs.wr_en = 0; bs.din = '0; bs.rd_en = 0; bs.clr_err = 0;
    b5.flush = 0; b5.wr_en = 0; b5.din = '0; b5.rd_en = 0; b5.clr_err = 0;

    // Fill 0x00..0x10 (17th write dropped), then drain 16 entries.
    for (int i = 0; i < 17; i++) begin
      tbl[i] = '{wr: 1, rd: 0, din: 8'(i), exp_level: (i + 1 > DEPTH) ? DEPTH : i + 1,
                 exp_full: (i >= DEPTH - 1), exp_af: (i + 1 >= AF), exp_ovf: (i == DEPTH),
                 exp_dout: 8'h00};
    end
    for (int j = 0; j < 16; j++) begin
      tbl[17 + j] = '{wr: 0, rd: 1, din: 8'h00, exp_level: 15 - j, exp_full: 0,
                      exp_af: (15 - j >= AF), exp_ovf: 1,
                      exp_dout: (j < 15) ? 8'(j + 1) : 8'h00};
    end

    // Reset state.
    cycle(1, 0, 0, 8'h00, 0, 0);
    cycle(1, 0, 1, 8'h3C, 1, 1);
    check("rst_empty",        32'(b0.empty),        32'd1);
    check("rst_almost_empty", 32'(b0.almost_empty), 32'd1);
    check("rst_full",         32'(b0.full),         32'd0);
    check("rst_level",        32'(b0.level),        32'd0);
    check("rst_d5_empty",     32'(b5.empty),        32'd1);

    // Table-driven fill/drain.
    for (int i = 0; i < 33; i++) begin
      cycle(0, 0, tbl[i].wr, tbl[i].din, tbl[i].rd, 0);
      check($sformatf("tbl%0d_level", i), 32'(b0.level),       32'(tbl[i].exp_level));
      check($sformatf("tbl%0d_full", i),  32'(b0.full),        32'(tbl[i].exp_full));
      check($sformatf("tbl%0d_af", i),    32'(b0.almost_full), 32'(tbl[i].exp_af));
      check($sformatf("tbl%0d_ovf", i),   32'(b0.overflow),    32'(tbl[i].exp_ovf));
      check($sformatf("tbl%0d_dout", i),  32'(b0.dout),        32'(tbl[i].exp_dout));
    end
    check("drain_empty", 32'(b0.empty), 32'd1);
    cycle(0, 0, 0, 8'h00, 0, 1);
    check("clr_ovf", 32'(b0.overflow), 32'd0);

    // Simultaneous read/write at level 5.
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 1, 8'($urandom), 1, 0);
      check("simul_level5", 32'(b0.level), 32'd5);
    end
    // At full: pop only, overflow set.
    for (int i = 0; i < 11; i++) cycle(0, 0, 1, 8'($urandom), 0, 0);
    cycle(0, 0, 1, 8'hEE, 1, 0);
    check("simul_full_level", 32'(b0.level),    32'd15);
    check("simul_full_ovf",   32'(b0.overflow), 32'd1);
    // At empty: write only, underflow set.
    for (int i = 0; i < 15; i++) cycle(0, 0, 0, 8'h00, 1, 0);
    cycle(0, 0, 1, 8'h77, 1, 0);
    check("simul_empty_level", 32'(b0.level),     32'd1);
    check("simul_empty_udf",   32'(b0.underflow), 32'd1);
    check("simul_empty_dout",  32'(b0.dout),      32'h77);
    cycle(0, 0, 0, 8'h00, 1, 1);

    // Registered read: 0xA5 appears exactly one cycle after rd_en.
    cycle(0, 1, 0, 8'h00, 0, 0);
    cycle(0, 0, 1, 8'hA5, 0, 0);
    check("std_no_fallthru", 32'(bs.rd_valid), 32'd0);
    cycle(0, 0, 0, 8'h00, 1, 0);
    check("std_a5_dout",  32'(bs.dout),     32'hA5);
    check("std_a5_valid", 32'(bs.rd_valid), 32'd1);
    cycle(0, 0, 0, 8'h00, 0, 0);
    check("std_valid_pulse", 32'(bs.rd_valid), 32'd0);
    check("std_dout_hold",   32'(bs.dout),     32'hA5);

    // Flush at level 7 with a concurrent write.
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, 8'(8'h40 + i), 0, 0);
    cycle(0, 0, 0, 8'h00, 1, 0);
    check("pre_flush_level", 32'(b0.level), 32'd7);
    cycle(0, 1, 1, 8'h99, 0, 0);
    check("flush_level", 32'(b0.level),     32'd0);
    check("flush_empty", 32'(b0.empty),     32'd1);
    check("flush_dout",  32'(b0.dout),      32'd0);
    check("flush_sdout", 32'(bs.dout),      32'd0);
    check("flush_ovf",   32'(b0.overflow),  32'd0);
    check("flush_udf",   32'(b0.underflow), 32'd0);

    // Depth 5: three laps, pointers wrap 4 -> 0.
    for (int lap = 0; lap < 3; lap++) begin
      for (int j = 0; j < 5; j++) begin
        cycle5(1, 8'(lap * 5 + j + 1), 0);
        check("d5_level_w", 32'(b5.level), 32'(j + 1));
      end
      check("d5_full", 32'(b5.full), 32'd1);
      for (int j = 0; j < 5; j++) begin
        check("d5_dout", 32'(b5.dout), 32'(lap * 5 + j + 1));
        cycle5(0, 8'h00, 1);
      end
      check("d5_empty", 32'(b5.empty), 32'd1);
    end

    // Randomised traffic with biased phases to reach full and empty.
    for (int i = 0; i < 2000; i++) begin
      bit w, rd, f, c;
      w  = ($urandom_range(0, 99) < ((((i / 200) % 2) == 1) ? 75 : 30));
      rd = ($urandom_range(0, 99) < ((((i / 200) % 2) == 1) ? 30 : 75));
      f  = ($urandom_range(0, 199) == 0);
      c  = !f && ($urandom_range(0, 49) == 0);
      cycle(0, f, w, 8'($urandom), rd, c);
    end

    // Reset mid-stream at level 9 with overflow set.
    cycle(0, 1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 17; i++) cycle(0, 0, 1, 8'(i), 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 0, 8'h00, 1, 0);
    check("mid_level", 32'(b0.level),    32'd9);
    check("mid_ovf",   32'(b0.overflow), 32'd1);
    cycle(1, 0, 1, 8'h55, 1, 0);
    check("mrst_level",    32'(b0.level),        32'd0);
    check("mrst_empty",    32'(b0.empty),        32'd1);
    check("mrst_ae",       32'(b0.almost_empty), 32'd1);
    check("mrst_af",       32'(b0.almost_full),  32'd0);
    check("mrst_dout",     32'(b0.dout),         32'd0);
    check("mrst_valid",    32'(b0.rd_valid),     32'd0);
    check("mrst_svalid",   32'(bs.rd_valid),     32'd0);
    check("mrst_ovf",      32'(b0.overflow),     32'd0);

    // clr_err against a same-cycle underflow event: event wins.
    cycle(0, 0, 0, 8'h00, 1, 1);
    check("clr_vs_udf", 32'(b0.underflow), 32'd1);
    cycle(0, 0, 0, 8'h00, 0, 1);
    check("clr_udf", 32'(b0.underflow), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
